// File: rtl/mux_stream_arb.sv
// N-to-1 stream multiplexer with a single-entry registered output stage.
// Channel choice is either a fixed index (mode 0) or round-robin over all channels (mode 1).
module mux_stream_arb #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  s,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_ch
);

    // Handshakes: a word moves on any rising edge where valid and ready are both high
    // on the same side; valid never depends on ready, ready may depend on valid.

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    logic          ld;
    logic          gnt;
    logic          take;
    logic [SW-1:0] g;
    logic [W-1:0]  sel_data;
    int            idx;

    assign ld   = !out_valid_q || out_ready;
    assign take = ld && gnt && !reset;

    // An out-of-range s simply never matches a channel, so no grant is produced.
    always_comb begin
        gnt      = 1'b0;
        g        = '0;
        sel_data = '0;
        idx      = 0;
        if (!mode) begin
            for (int k = 0; k < N; k++) begin
                if (!gnt && s == SW'(k) && in_valid[k]) begin
                    gnt      = 1'b1;
                    g        = SW'(k);
                    sel_data = in_data[k*W +: W];
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!gnt && in_valid[idx]) begin
                    gnt      = 1'b1;
                    g        = SW'(idx);
                    sel_data = in_data[idx*W +: W];
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            if (take && g == SW'(k)) begin
                in_ready[k] = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (ld) begin
            out_valid_d = gnt;
            if (gnt) begin
                out_data_d = sel_data;
                out_ch_d   = g;
            end
        end
        // Pointer wraps at N rather than 2^SW so non-power-of-two N stays in range.
        if (ld && gnt && mode) begin
            rr_ptr_d = (int'(g) == N - 1) ? '0 : SW'(int'(g) + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_stream_arb.sv
// Directed bench for mux_stream_arb: a 4-channel instance for the main scenarios and a
// 5-channel instance for the out-of-range select case.
module tb_mux_stream_arb;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  s;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        mode5;
    logic [2:0]  s5;
    logic [7:0]  out_data5;
    logic        out_valid5;
    logic        out_ready5;
    logic [2:0]  out_ch5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_stream_arb #(.N(4), .W(8)) u0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .s(s), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    mux_stream_arb #(.N(5), .W(8)) u1 (
        .clk(clk), .reset(reset), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(in_ready5), .mode(mode5), .s(s5), .out_data(out_data5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_ch(out_ch5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte4(input int ch);
        logic [31:0] d;
        d = 32'h33A52211;
        return d[ch*8 +: 8];
    endfunction

    initial begin
        int exp_seq[5];
        exp_seq = '{0, 1, 3, 1, 3};

        reset      = 1'b1;
        in_data    = 32'h33A52211;
        in_valid   = 4'b1111;
        mode       = 1'b1;
        s          = 2'd0;
        out_ready  = 1'b1;
        in_data5   = 40'h55_44_33_22_11;
        in_valid5  = 5'b00000;
        mode5      = 1'b0;
        s5         = 3'd0;
        out_ready5 = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 4'b0000);
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_ch", out_ch, 2'd0);
        chk("rst_out_valid5", out_valid5, 1'b0);

        // Fixed select of channel 2.
        reset = 1'b0;
        mode  = 1'b0;
        s     = 2'd2;
        #1;
        chk("fix_in_ready", in_ready, 4'b0100);
        step();
        chk("fix_out_data", out_data, 8'hA5);
        chk("fix_out_ch", out_ch, 2'd2);
        chk("fix_out_valid", out_valid, 1'b1);

        // Round-robin, all valid: 0,1,2,3,0,1,2,3 then 0,1 to park the pointer at 2.
        mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #0;
            chk("rr_in_ready", in_ready, 32'(1) << (i % 4));
            step();
            chk("rr_out_ch", out_ch, i % 4);
            chk("rr_out_data", out_data, byte4(i % 4));
            chk("rr_out_valid", out_valid, 1'b1);
        end

        // Sparse valid from pointer 2: channel 3, 1, 3.
        in_valid = 4'b1010;
        for (int i = 2; i < 5; i++) begin
            #0;
            chk("sparse_in_ready", in_ready, 32'(1) << exp_seq[i]);
            step();
            chk("sparse_out_ch", out_ch, exp_seq[i]);
        end

        // Backpressure: word from channel 3 must hold for five cycles.
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #0;
            chk("bp_in_ready", in_ready, 4'b0000);
            step();
            chk("bp_out_ch", out_ch, 2'd3);
            chk("bp_out_data", out_data, 8'h33);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #0;
        chk("bp_release_in_ready", in_ready, 4'b0001);
        step();
        chk("bp_replace_ch", out_ch, 2'd0);
        chk("bp_replace_data", out_data, 8'h11);

        // A select change while stalled leaves the held word alone.
        out_ready = 1'b0;
        mode      = 1'b0;
        s         = 2'd1;
        step();
        chk("modechg_hold_ch", out_ch, 2'd0);
        chk("modechg_hold_data", out_data, 8'h11);
        out_ready = 1'b1;
        #0;
        chk("modechg_in_ready", in_ready, 4'b0010);
        step();
        chk("modechg_out_ch", out_ch, 2'd1);

        // No grant: output drains, data and channel keep their values.
        in_valid = 4'b0000;
        #0;
        chk("idle_in_ready", in_ready, 4'b0000);
        step();
        chk("idle_out_valid", out_valid, 1'b0);
        chk("idle_out_ch", out_ch, 2'd1);
        chk("idle_out_data", out_data, 8'h22);

        // Pointer stayed at 1 through the fixed-mode grant.
        mode     = 1'b1;
        in_valid = 4'b1111;
        #0;
        chk("ptr_hold_in_ready", in_ready, 4'b0010);
        step();
        chk("ptr_hold_out_ch", out_ch, 2'd1);

        // Reset while a word is buffered and all inputs are offering.
        reset = 1'b1;
        #0;
        chk("midrst_in_ready", in_ready, 4'b0000);
        step();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, 8'h00);
        chk("midrst_out_ch", out_ch, 2'd0);
        reset = 1'b0;
        #0;
        chk("postrst_in_ready", in_ready, 4'b0001);
        step();
        chk("postrst_out_ch", out_ch, 2'd0);
        chk("postrst_out_data", out_data, 8'h11);

        // Five-channel instance: valid select 4, then out-of-range select 6.
        in_valid5 = 5'b11111;
        s5        = 3'd4;
        #0;
        chk("n5_in_ready", in_ready5, 5'b10000);
        step();
        chk("n5_out_data", out_data5, 8'h55);
        chk("n5_out_ch", out_ch5, 3'd4);
        s5         = 3'd6;
        out_ready5 = 1'b0;
        step();
        chk("n5_hold_valid", out_valid5, 1'b1);
        out_ready5 = 1'b1;
        #0;
        chk("n5_oor_in_ready", in_ready5, 5'b00000);
        step();
        chk("n5_oor_out_valid", out_valid5, 1'b0);
        chk("n5_oor_out_ch", out_ch5, 3'd4);
        chk("n5_oor_in_ready2", in_ready5, 5'b00000);
        step();
        chk("n5_oor_out_valid2", out_valid5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_stream_arb.md
MUX_STREAM_ARB -- requirements
Module: mux_stream_arb

Interface
REQ-001: Parameter N, default 4: number of input channels, N >= 2, power of two not required.
REQ-002: Parameter W, default 8: data width per channel, W >= 1.
REQ-003: Parameter SW = $clog2(N): derived select and channel-index width, not overridden.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: in_data  input  N*W  channel k data at bits [k*W +: W].
REQ-007: in_valid  input  N  channel k offers a word when bit k is 1.
REQ-008: in_ready  output  N  channel k word is consumed on an edge where in_valid[k] and in_ready[k] are both 1.
REQ-009: mode  input  1  0 = fixed select by s; 1 = round-robin over all channels.
REQ-010: s  input  SW  channel index used when mode = 0.
REQ-011: out_data  output  W  registered output word.
REQ-012: out_valid  output  1  out_data holds an unconsumed word.
REQ-013: out_ready  input  1  downstream accepts the word on an edge where out_valid and out_ready are both 1.
REQ-014: out_ch  output  SW  index of the channel that supplied out_data.

Function
REQ-015: The block SHALL hold a single-entry output register (out_data, out_ch, out_valid).
REQ-016: Load enable ld = !out_valid | out_ready, combinational.
REQ-017: Grant g is combinational. When mode = 0, g = s if s < N and in_valid[s] = 1; otherwise there is no grant.
REQ-018: When mode = 1, g is the first k with in_valid[k] = 1, searching from rr_ptr upward modulo N; with no valid channel there is no grant.
REQ-019: in_ready[k] = ld & (grant exists) & (g == k); at most one in_ready bit is 1 in any cycle.
REQ-020: On an edge with ld = 1 and a grant: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
REQ-021: On an edge with ld = 1 and no grant: out_valid <= 0; out_data and out_ch keep their values.
REQ-022: While out_valid = 1 and out_ready = 0, out_data, out_ch and out_valid SHALL remain stable and in_ready SHALL be all zero.
REQ-023: Latency from input handshake to out_valid = 1 SHALL be one clock; with out_ready held at 1, throughput SHALL be one word per clock.
REQ-024: rr_ptr (SW bits) updates only on a granted transfer with mode = 1: rr_ptr <= (g == N-1) ? 0 : g+1, wrapping at N, not at 2^SW.
REQ-025: rr_ptr SHALL NOT change while mode = 0.
REQ-026: A mode or s change SHALL affect only the next grant; a word already in the output register is unaffected.
REQ-027: If s >= N (N not a power of two) in mode 0, there is no grant, in_ready is all zero, and no data is lost.
REQ-028: Simultaneous output consume and input grant in one cycle SHALL replace the word with no bubble.
REQ-029: A channel's in_data SHALL be sampled only in the cycle of its handshake; the block performs no other input buffering.

Reset
REQ-030: While reset = 1 at an edge: out_valid <= 0, out_data <= 0, out_ch <= 0, rr_ptr <= 0.
REQ-031: in_ready SHALL be all zero in any cycle where reset = 1.
REQ-032: Reset asserted mid-transfer SHALL discard the buffered word; no handshake completes on that edge.
REQ-033: After reset is released, the first round-robin grant SHALL favour channel 0.

Verification
REQ-034: Fixed mode, N=4, W=8, s=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; the next cycle gives out_data=8'hA5, out_ch=2, out_valid=1.
REQ-035: Round-robin, all four valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no idle cycles.
REQ-036: Round-robin, in_valid=4'b1010, rr_ptr=2 -> grant ch3, then ch1, then ch3; ch0 and ch2 are never granted.
REQ-037: Backpressure: out_valid=1 with out_ready=0 for 5 cycles -> out_data and out_ch stable and in_ready=0 throughout; on out_ready=1, the word is replaced by the next grant in the same edge.
REQ-038: N=5, mode=0, s=6 with all channels valid -> in_ready=0 and out_valid falls to 0 after the pending word is consumed.
REQ-039: Reset asserted while out_valid=1 and in_valid=all ones -> the next cycle gives out_valid=0, out_data=0, out_ch=0; the first round-robin grant after release is ch0.
